pipeline_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage RV32I pipeline. It drives the load enables and bubble selects of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Each bubble select chooses between the incoming control word and an all-zero NOP control word. The controller resolves memory-wait freezes, load-use hazards and taken-branch redirects, including squashing a stale instruction-fetch response that was in flight when a redirect occurred.

---
 rtl/pipeline_hazard_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: memory-wait freeze, load-use bubble, redirect flush and stale-fetch squash.
// Optional define HAZARD_PERF_EN adds the perf_stall_cycles / perf_flushes counters.
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_br_taken,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        sel_if_id,
    output logic        sel_id_ex,
    output logic        sel_mem_wb,
    output logic [1:0]  dbg_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes
`endif
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   dstall;
    logic   load_use;
    logic   flush_fire;

    assign dstall   = dmem_req & ~dmem_resp;
    assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        sel_if_id   = 1'b0;
        sel_id_ex   = 1'b0;
        sel_mem_wb  = 1'b0;
        flush_fire  = 1'b0;

        // Reset shares the INIT output pattern so WB is flushed while rst is held.
        if (rst || state == ST_INIT) begin
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            sel_if_id   = 1'b1;
            sel_id_ex   = 1'b1;
            sel_mem_wb  = 1'b1;
            state_nxt   = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (dstall) begin
                        state_nxt = ST_RUN;
                    end else if (ex_br_taken) begin
                        load_pc     = 1'b1;
                        load_if_id  = 1'b1;
                        load_id_ex  = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                        sel_if_id   = 1'b1;
                        sel_id_ex   = 1'b1;
                        flush_fire  = 1'b1;
                        state_nxt   = imem_resp ? ST_RUN : ST_SQUASH;
                    end else if (!imem_resp || load_use) begin
                        load_id_ex  = 1'b1;
                        sel_id_ex   = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                    end else begin
                        load_pc     = 1'b1;
                        load_if_id  = 1'b1;
                        load_id_ex  = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                    end
                end
                ST_SQUASH: begin
                    if (dstall) begin
                        state_nxt = ST_SQUASH;
                    end else if (imem_resp) begin
                        // The arriving word belongs to the pre-redirect PC: drop it as a NOP.
                        load_if_id  = 1'b1;
                        sel_if_id   = 1'b1;
                        load_id_ex  = 1'b1;
                        sel_id_ex   = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                        state_nxt   = ST_RUN;
                    end else begin
                        load_id_ex  = 1'b1;
                        sel_id_ex   = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                    end
                end
                default: state_nxt = ST_INIT;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= 32'd0;
            perf_flushes      <= 32'd0;
        end else begin
            if (state != ST_INIT && !load_pc) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (flush_fire) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

endmodule
